// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and small decode helpers used by the top level.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PREP = 2'b01,
        S_CALC = 2'b10,
        S_FIX  = 2'b11
    } mdu_state_e;

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// One-step-per-cycle datapath shared by multiply (shift-add) and divide
// (restoring subtract) on a 2*WIDTH+1-bit accumulator.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [2*WIDTH:0]   load_val,
    input  logic               step_en,
    input  logic               mode,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc
);

    localparam int AW = 2 * WIDTH + 1;

    logic [AW-1:0]    acc_q;
    logic [AW-1:0]    acc_next;
    logic [AW-1:0]    shifted;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   upper_mul;
    logic [WIDTH+1:0] diff;

    // Next accumulator value: mode 0 adds then shifts right, mode 1 shifts left then trial-subtracts
    always_comb begin
        sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        shifted   = {acc_q[AW-2:0], 1'b0};
        diff      = {1'b0, shifted[AW-1:WIDTH]} - {2'b00, operand};
        upper_mul = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        acc_next  = acc_q;
        if (mode) begin
            if (diff[WIDTH+1]) begin
                acc_next = shifted;
            end else begin
                acc_next = {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
            end
        end else begin
            if (acc_q[0]) begin
                upper_mul = sum;
            end else begin
                upper_mul = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
            end
            acc_next = {1'b0, upper_mul, acc_q[WIDTH-1:1]};
        end
    end

    // Accumulator register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= {AW{1'b0}};
        end else if (load) begin
            acc_q <= load_val;
        end else if (step_en) begin
            acc_q <= acc_next;
        end else begin
            acc_q <= acc_q;
        end
    end

    assign acc = acc_q[2*WIDTH-1:0];

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MIPS multiply/divide unit with HI/LO registers: FSM, step counter,
// sign fix-up and HI/LO storage around the shared mdu_iter datapath.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

    mdu_state_e         state;
    mdu_state_e         next_state;
    mdu_op_e            op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   b_mag;
    logic               res_neg;
    logic               rem_neg;
    logic [CW-1:0]      count;
    logic               load;
    logic               step_en;
    logic               is_signed;
    logic               is_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag_c;
    logic [WIDTH-1:0]   b_mag_c;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // Operand magnitudes and sign decode from the latched operation
    always_comb begin
        is_signed = op_is_signed(op_q);
        is_div    = op_is_div(op_q);
        a_neg     = is_signed & a_q[WIDTH-1];
        b_neg     = is_signed & b_q[WIDTH-1];
        a_mag_c   = a_neg ? (-a_q) : a_q;
        b_mag_c   = b_neg ? (-b_q) : b_q;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath control
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step_en    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_PREP;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_PREP: begin
                load       = 1'b1;
                next_state = S_CALC;
            end
            S_CALC: begin
                step_en = 1'b1;
                if (count == LAST) begin
                    next_state = S_FIX;
                end else begin
                    next_state = S_CALC;
                end
            end
            S_FIX: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Operand capture at launch; later changes on a/b are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= MDU_MULT;
            a_q  <= {WIDTH{1'b0}};
            b_q  <= {WIDTH{1'b0}};
        end else if ((state == S_IDLE) && start) begin
            op_q <= mdu_op_e'(op);
            a_q  <= a;
            b_q  <= b;
        end else begin
            op_q <= op_q;
            a_q  <= a_q;
            b_q  <= b_q;
        end
    end

    // Magnitude of b and result signs, recorded during PREP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_mag   <= {WIDTH{1'b0}};
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
        end else if (state == S_PREP) begin
            b_mag   <= b_mag_c;
            res_neg <= a_neg ^ b_neg;
            rem_neg <= a_neg;
        end else begin
            b_mag   <= b_mag;
            res_neg <= res_neg;
            rem_neg <= rem_neg;
        end
    end

    // Step counter, active only while iterating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= {CW{1'b0}};
        end else if ((state == S_CALC) && (count != LAST)) begin
            count <= count + ONE;
        end else begin
            count <= {CW{1'b0}};
        end
    end

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val ({{(WIDTH+1){1'b0}}, a_mag_c}),
        .step_en  (step_en),
        .mode     (is_div),
        .operand  (b_mag),
        .acc      (acc)
    );

    // Sign fix-up; divide by zero returns the raw dividend in HI
    always_comb begin
        prod_fix = res_neg ? (-acc) : acc;
        quot_fix = res_neg ? (-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem_fix  = rem_neg ? (-acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
        if (is_div) begin
            if (b_q == {WIDTH{1'b0}}) begin
                fix_hi = a_q;
                fix_lo = {WIDTH{1'b1}};
            end else begin
                fix_hi = rem_fix;
                fix_lo = quot_fix;
            end
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    // HI/LO update: result at FIX, mthi/mtlo only when idle and not starting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= {WIDTH{1'b0}};
            lo <= {WIDTH{1'b0}};
        end else if (state == S_FIX) begin
            hi <= fix_hi;
            lo <= fix_lo;
        end else if ((state == S_IDLE) && !start) begin
            hi <= mthi ? a : hi;
            lo <= mtlo ? a : lo;
        end else begin
            hi <= hi;
            lo <= lo;
        end
    end

    // Completion pulse in the cycle after FIX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (state == S_FIX);
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: directed operations push expected HI/LO and
// arrival cycle; a negedge monitor pops and compares on every done pulse.
module tb_mdu_hilo;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          at;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    mdu_hilo #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done actual=done required=no_done at cycle %0d", cyc);
            end else begin
                e = sbq.pop_front();
                chk("result_hi", hi, e.hi);
                chk("result_lo", lo, e.lo);
                chk("done_cycle", cyc, e.at);
            end
        end
    end

    // Launch one operation; optionally queue its expected result
    task automatic issue(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input logic with_mthi, input logic push);
        @(negedge clk);
        op    = o;
        a     = va;
        b     = vb;
        start = 1'b1;
        mthi  = with_mthi;
        if (push) sbq.push_back('{ehi, elo, cyc + 35});
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        a     = $urandom;
        b     = $urandom;
        chk("busy_cycle1", {31'd0, busy}, 32'd1);
    endtask

    // Bounded wait for idle; busy must last exactly 34 cycles
    task automatic wait_idle();
        int n = 1;
        while (busy && n < 60) begin
            @(negedge clk);
            if (busy) n++;
        end
        chk("busy_len", n, 32'd34);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        mthi = 1'b0; mtlo = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        issue(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1); wait_idle();
        issue(MDU_MULT,  32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b1); wait_idle();
        issue(MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1); wait_idle();
        issue(MDU_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0, 1'b1); wait_idle();
        issue(MDU_DIV,   32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b0, 1'b1); wait_idle();
        issue(MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 1'b1); wait_idle();
        issue(MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 1'b1); wait_idle();
        issue(MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        1'b0, 1'b1); wait_idle();
        issue(MDU_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b1); wait_idle();

        // start and mthi/mtlo while busy are ignored
        issue(MDU_MULTU, 32'h00010000, 32'h00010000, 32'd1, 32'd0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        start = 1'b1; op = MDU_DIV; a = 32'h0000DEAD; b = 32'd5; mthi = 1'b1; mtlo = 1'b1;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        chk("busy_hi_hold", hi, 32'd0);
        repeat (40) begin
            if (busy) @(negedge clk);
        end
        @(negedge clk);

        // mthi/mtlo while idle
        a = 32'h000000A5; mthi = 1'b1; mtlo = 1'b1;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        chk("mthilo_hi", hi, 32'h000000A5);
        chk("mthilo_lo", lo, 32'h000000A5);
        a = 32'h00000077; mthi = 1'b1;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi_hi", hi, 32'h00000077);
        chk("mthi_lo", lo, 32'h000000A5);

        // mthi in the same cycle as start loses to start
        issue(MDU_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b1, 1'b1);
        chk("start_prio_hi", hi, 32'h00000077);
        wait_idle();

        // reset in the middle of CALC aborts with no done
        issue(MDU_DIVU, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        issue(MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1); wait_idle();

        repeat (3) @(negedge clk);
        chk("queue_empty", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
